// File: rtl/bp_pc_histogram_profiler.sv
// rtl/bp_pc_histogram_profiler.sv - per-PC retired-instruction histogram with drain port
// Direct-mapped, PC-tagged table of saturating counters, drained over a valid/ready port.
module bp_pc_histogram_profiler #(
  parameter int vaddr_width_p = 39,
  parameter int entries_p     = 64,
  parameter int count_width_p = 32,
  parameter int replace_p     = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     freeze_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic                     dump_i,
  output logic                     dump_v_o,
  output logic [vaddr_width_p-1:0] dump_pc_o,
  output logic [count_width_p-1:0] dump_count_o,
  input  logic                     dump_ready_i,
  output logic                     dump_done_o,
  output logic                     busy_o,
  output logic [count_width_p-1:0] conflict_count_o,
  output logic [count_width_p-1:0] drop_count_o
);

  localparam int idx_width_lp = $clog2(entries_p);
  localparam logic [count_width_p-1:0] count_max_lp = {count_width_p{1'b1}};
  localparam logic [count_width_p-1:0] count_one_lp = count_width_p'(1);
  localparam logic [idx_width_lp-1:0]  ptr_last_lp  = idx_width_lp'(entries_p - 1);
  localparam logic [idx_width_lp-1:0]  ptr_one_lp   = idx_width_lp'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e                   state_r, state_n;
  logic [idx_width_lp-1:0]  ptr_r, ptr_n;
  logic [entries_p-1:0]     valid_r;
  logic [vaddr_width_p-1:0] tag_r   [entries_p];
  logic [count_width_p-1:0] count_r [entries_p];
  logic [count_width_p-1:0] conflict_r, drop_r;

  // Bit 0 of the PC is always zero for 2-byte aligned (compressed) code.
  logic [idx_width_lp-1:0] idx;
  logic commit_live, accept, drop, hit, conflict, clear, advance;

  assign idx         = commit_pc_i[1 +: idx_width_lp];
  assign commit_live = commit_v_i & ~freeze_i;
  assign accept      = commit_live & (state_r == IDLE);
  assign drop        = commit_live & (state_r != IDLE);
  assign hit         = valid_r[idx] & (tag_r[idx] == commit_pc_i);
  assign conflict    = accept & valid_r[idx] & ~hit;

  assign dump_v_o     = (state_r == DRAIN) & valid_r[ptr_r];
  assign dump_pc_o    = dump_v_o ? tag_r[ptr_r]   : '0;
  assign dump_count_o = dump_v_o ? count_r[ptr_r] : '0;
  assign clear        = dump_v_o & dump_ready_i;
  assign advance      = (state_r == DRAIN) & (~valid_r[ptr_r] | dump_ready_i);
  assign busy_o       = (state_r != IDLE);

  assign conflict_count_o = conflict_r;
  assign drop_count_o     = drop_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r   <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
    end
  end

  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    dump_done_o = 1'b0;
    case (state_r)
      IDLE: begin
        if (dump_i) begin
          state_n = DRAIN;
          ptr_n   = '0;
        end
      end
      DRAIN: begin
        if (advance) begin
          ptr_n = ptr_r + ptr_one_lp;
          if (ptr_r == ptr_last_lp) state_n = DONE;
        end
      end
      DONE: begin
        dump_done_o = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Commits only land in IDLE and clears only happen in DRAIN, so they never collide.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_r <= '0;
      for (int i = 0; i < entries_p; i++) begin
        tag_r[i]   <= '0;
        count_r[i] <= '0;
      end
    end else if (accept) begin
      if (hit) begin
        if (count_r[idx] != count_max_lp) count_r[idx] <= count_r[idx] + count_one_lp;
      end else if (!valid_r[idx]) begin
        valid_r[idx] <= 1'b1;
        tag_r[idx]   <= commit_pc_i;
        count_r[idx] <= count_one_lp;
      end else if (replace_p != 0) begin
        tag_r[idx]   <= commit_pc_i;
        count_r[idx] <= count_one_lp;
      end
    end else if (clear) begin
      valid_r[ptr_r] <= 1'b0;
      count_r[ptr_r] <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      conflict_r <= '0;
      drop_r     <= '0;
    end else begin
      if (conflict && conflict_r != count_max_lp) conflict_r <= conflict_r + count_one_lp;
      if (drop && drop_r != count_max_lp)         drop_r     <= drop_r + count_one_lp;
    end
  end

endmodule

// File: tb/tb_bp_pc_histogram_profiler.sv
// tb/tb_bp_pc_histogram_profiler.sv - directed self-checking bench for bp_pc_histogram_profiler
// Three instances share stimulus: a = defaults, b = replace_p 1, c = count_width_p 4.
module tb_bp_pc_histogram_profiler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        commit_v = 1'b0;
  logic [38:0] commit_pc = '0;
  logic        dump = 1'b0;
  logic        ready = 1'b1;

  logic        dv_a, done_a, busy_a;
  logic [38:0] pc_a;
  logic [31:0] cnt_a, conf_a, drop_a;
  logic        dv_b, done_b, busy_b;
  logic [38:0] pc_b;
  logic [31:0] cnt_b, conf_b, drop_b;
  logic        dv_c, done_c, busy_c;
  logic [38:0] pc_c;
  logic [3:0]  cnt_c, conf_c, drop_c;

  int checks = 0;
  int errors = 0;
  int busy_cycles;
  logic done_seen;
  logic [63:0] qa_pc[$], qa_cnt[$], qb_pc[$], qb_cnt[$], qc_pc[$], qc_cnt[$];

  always #5 clk = ~clk;

  bp_pc_histogram_profiler u_a (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .commit_v_i(commit_v), .commit_pc_i(commit_pc),
    .dump_i(dump), .dump_v_o(dv_a), .dump_pc_o(pc_a), .dump_count_o(cnt_a), .dump_ready_i(ready),
    .dump_done_o(done_a), .busy_o(busy_a), .conflict_count_o(conf_a), .drop_count_o(drop_a));

  bp_pc_histogram_profiler #(.replace_p(1)) u_b (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .commit_v_i(commit_v), .commit_pc_i(commit_pc),
    .dump_i(dump), .dump_v_o(dv_b), .dump_pc_o(pc_b), .dump_count_o(cnt_b), .dump_ready_i(ready),
    .dump_done_o(done_b), .busy_o(busy_b), .conflict_count_o(conf_b), .drop_count_o(drop_b));

  bp_pc_histogram_profiler #(.count_width_p(4)) u_c (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .commit_v_i(commit_v), .commit_pc_i(commit_pc),
    .dump_i(dump), .dump_v_o(dv_c), .dump_pc_o(pc_c), .dump_count_o(cnt_c), .dump_ready_i(ready),
    .dump_done_o(done_c), .busy_o(busy_c), .conflict_count_o(conf_c), .drop_count_o(drop_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_n(input logic [38:0] pc, input int n);
    commit_v  = 1'b1;
    commit_pc = pc;
    repeat (n) tick();
    commit_v = 1'b0;
  endtask

  // Pulses dump (optionally with a same-cycle commit) and collects every beat until dump_done.
  task automatic drain(input logic cv, input logic [38:0] cpc);
    qa_pc.delete(); qa_cnt.delete(); qb_pc.delete(); qb_cnt.delete(); qc_pc.delete(); qc_cnt.delete();
    busy_cycles = 0;
    done_seen   = 1'b0;
    ready       = 1'b1;
    dump        = 1'b1;
    commit_v    = cv;
    commit_pc   = cpc;
    tick();
    dump     = 1'b0;
    commit_v = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      if (busy_a) busy_cycles++;
      if (dv_a) begin qa_pc.push_back(64'(pc_a)); qa_cnt.push_back(64'(cnt_a)); end
      if (dv_b) begin qb_pc.push_back(64'(pc_b)); qb_cnt.push_back(64'(cnt_b)); end
      if (dv_c) begin qc_pc.push_back(64'(pc_c)); qc_cnt.push_back(64'(cnt_c)); end
      if (done_a) done_seen = 1'b1;
      tick();
    end
    check("drain_done_seen", done_seen, 1);
    check("idle_after_drain", {done_a, busy_a}, 0);
  endtask

  logic [38:0] hold_pc;
  logic [31:0] hold_cnt;
  logic        stable;
  logic        seen;

  initial begin
    // reset state
    tick(); tick();
    check("rst_dump_v", dv_a, 0);
    check("rst_dump_pc", pc_a, 0);
    check("rst_dump_count", cnt_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_conflict", conf_a, 0);
    check("rst_drop", drop_a, 0);
    rst = 1'b0;
    tick();

    // basic histogram and ascending-index drain
    commit_n(39'h80000000, 5);
    commit_n(39'h80000004, 3);
    drain(1'b0, '0);
    check("main_beats", qa_pc.size(), 2);
    check("main_b0_pc", qa_pc.size() > 0 ? qa_pc[0] : 64'hdead, 64'h80000000);
    check("main_b0_cnt", qa_cnt.size() > 0 ? qa_cnt[0] : 64'hdead, 5);
    check("main_b1_pc", qa_pc.size() > 1 ? qa_pc[1] : 64'hdead, 64'h80000004);
    check("main_b1_cnt", qa_cnt.size() > 1 ? qa_cnt[1] : 64'hdead, 3);
    check("main_busy_cycles", busy_cycles, 65);
    check("main_c_b1_cnt", qc_cnt.size() > 1 ? qc_cnt[1] : 64'hdead, 3);

    // drained table is empty
    drain(1'b0, '0);
    check("empty_beats", qa_pc.size(), 0);

    // conflict policies
    commit_n(39'h80000000, 2);
    commit_n(39'h80000080, 1);
    check("conf_a", conf_a, 1);
    check("conf_b", conf_b, 1);
    drain(1'b0, '0);
    check("conf_a_beats", qa_pc.size(), 1);
    check("conf_a_pc", qa_pc.size() > 0 ? qa_pc[0] : 64'hdead, 64'h80000000);
    check("conf_a_cnt", qa_cnt.size() > 0 ? qa_cnt[0] : 64'hdead, 2);
    check("conf_b_pc", qb_pc.size() > 0 ? qb_pc[0] : 64'hdead, 64'h80000080);
    check("conf_b_cnt", qb_cnt.size() > 0 ? qb_cnt[0] : 64'hdead, 1);
    check("conf_kept", conf_a, 1);

    // saturation at count_width_p = 4
    commit_n(39'h80000010, 20);
    drain(1'b0, '0);
    check("sat_a_cnt", qa_cnt.size() > 0 ? qa_cnt[0] : 64'hdead, 20);
    check("sat_c_cnt", qc_cnt.size() > 0 ? qc_cnt[0] : 64'hdead, 15);
    check("sat_c_pc", qc_pc.size() > 0 ? qc_pc[0] : 64'hdead, 64'h80000010);

    // frozen commits are ignored; a commit alongside dump is applied
    freeze = 1'b1;
    commit_n(39'h80000020, 4);
    commit_n(39'h80000000, 2);
    freeze = 1'b0;
    check("frz_conf", conf_a, 1);
    check("frz_drop", drop_a, 0);
    drain(1'b1, 39'h80000030);
    check("frz_beats", qa_pc.size(), 1);
    check("frz_pc", qa_pc.size() > 0 ? qa_pc[0] : 64'hdead, 64'h80000030);
    check("frz_cnt", qa_cnt.size() > 0 ? qa_cnt[0] : 64'hdead, 1);

    // backpressure, stability and drops
    commit_n(39'h80000040, 2);
    ready = 1'b0;
    dump  = 1'b1;
    tick();
    dump = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (dv_a) seen = 1'b1;
      else tick();
    end
    check("bp_valid_seen", seen, 1);
    check("bp_pc", pc_a, 39'h80000040);
    check("bp_cnt", cnt_a, 2);
    hold_pc  = pc_a;
    hold_cnt = cnt_a;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      commit_v  = (i < 3) || (i == 5);
      freeze    = (i == 5);
      commit_pc = 39'h80000040;
      if (!dv_a || pc_a !== hold_pc || cnt_a !== hold_cnt) stable = 1'b0;
      tick();
    end
    commit_v = 1'b0;
    freeze   = 1'b0;
    check("bp_stable", stable, 1);
    check("bp_drop_a", drop_a, 3);
    check("bp_drop_c", drop_c, 3);
    ready = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done_a) seen = 1'b1;
      tick();
    end
    check("bp_done", seen, 1);
    drain(1'b0, '0);
    check("bp_second_beats", qa_pc.size(), 0);
    check("bp_drop_kept", drop_a, 3);

    // asynchronous reset mid-drain
    commit_n(39'h80000000, 1);
    ready = 1'b0;
    dump  = 1'b1;
    tick();
    dump = 1'b0;
    tick();
    check("mid_valid_before", dv_a, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", dv_a, 0);
    check("mid_rst_pc", pc_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_drop", drop_a, 0);
    check("mid_rst_conf", conf_a, 0);
    check("mid_rst_done", done_a, 0);
    tick();
    rst = 1'b0;
    tick();
    drain(1'b0, '0);
    check("post_rst_beats", qa_pc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
